// File: rtl/pe_tilde_butterfly_if.sv
// Coefficient-pair bus for the unity-twiddle butterfly PE: runtime modulus,
// operand pair in, reduced sum/difference pair out.
interface pe_tilde_butterfly_if #(
    parameter int DATA_SIZE_ARB = 16
);
    logic [DATA_SIZE_ARB-1:0] q;
    logic [DATA_SIZE_ARB-1:0] data_top_i;
    logic [DATA_SIZE_ARB-1:0] data_bot_i;
    logic [DATA_SIZE_ARB-1:0] ntt_top_o;
    logic [DATA_SIZE_ARB-1:0] ntt_bot_o;

    modport master (
        output q, data_top_i, data_bot_i,
        input  ntt_top_o, ntt_bot_o
    );

    modport slave (
        input  q, data_top_i, data_bot_i,
        output ntt_top_o, ntt_bot_o
    );
endinterface

// File: rtl/pe_tilde_butterfly.sv
// Radix-2 NTT butterfly with twiddle fixed at 1: registers ((a+b) mod q, (a-b) mod q).
// Each path uses a single widened conditional correction, so no multiplier or divider.
module pe_tilde_butterfly #(
    parameter int DATA_SIZE_ARB = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pe_tilde_butterfly_if.slave  bus
);
    localparam int W = DATA_SIZE_ARB;

    logic [W:0]   q_ext;
    logic [W:0]   sum_ext;
    logic [W:0]   diff_ext;
    logic [W:0]   bot_fix_ext;
    logic [W-1:0] top_next;
    logic [W-1:0] bot_next;
    logic [W-1:0] top_reg;
    logic [W-1:0] bot_reg;

    assign q_ext    = {1'b0, bus.q};
    assign sum_ext  = {1'b0, bus.data_top_i} + {1'b0, bus.data_bot_i};
    assign diff_ext = {1'b0, bus.data_top_i} - {1'b0, bus.data_bot_i};
    // The extra MSB of the difference is the borrow, i.e. a < b.
    assign bot_fix_ext = diff_ext + q_ext;

    always_comb begin
        top_next = sum_ext[W-1:0];
        bot_next = diff_ext[W-1:0];
        if (sum_ext >= q_ext) begin
            top_next = sum_ext[W-1:0] - bus.q;
        end
        if (diff_ext[W]) begin
            bot_next = bot_fix_ext[W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_reg <= '0;
            bot_reg <= '0;
        end else begin
            top_reg <= top_next;
            bot_reg <= bot_next;
        end
    end

    assign bus.ntt_top_o = top_reg;
    assign bus.ntt_bot_o = bot_reg;
endmodule

// File: tb/tb_pe_tilde_butterfly.sv
// Bench for pe_tilde_butterfly: directed vector table, reset/hold sequences
// and a random sweep against a modular-arithmetic reference.
module tb_pe_tilde_butterfly;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;

    pe_tilde_butterfly_if #(.DATA_SIZE_ARB(W)) bus ();

    pe_tilde_butterfly #(.DATA_SIZE_ARB(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned q;
        int unsigned a;
        int unsigned b;
        int unsigned exp_top;
        int unsigned exp_bot;
    } vec_t;

    vec_t vecs [14];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int unsigned qv, input int unsigned a, input int unsigned b);
        bus.q          = W'(qv);
        bus.data_top_i = W'(a);
        bus.data_bot_i = W'(b);
    endtask

    // Drive at the falling edge, let one rising edge capture, sample just after it.
    task automatic apply(input int unsigned qv, input int unsigned a, input int unsigned b);
        @(negedge clk);
        drive(qv, a, b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned hold_top;
        int unsigned hold_bot;
        int unsigned ra;
        int unsigned rb;

        vecs[0]  = '{7681, 100,  50,   150,  50};
        vecs[1]  = '{7681, 7000, 1000, 319,  6000};
        vecs[2]  = '{7681, 10,   20,   30,   7671};
        vecs[3]  = '{7681, 7680, 7680, 7679, 0};
        vecs[4]  = '{7681, 0,    0,    0,    0};
        vecs[5]  = '{7681, 4000, 3681, 0,    319};
        vecs[6]  = '{7681, 3681, 4000, 0,    7362};
        vecs[7]  = '{65521, 65520, 65520, 65519, 0};
        vecs[8]  = '{65521, 0,     65520, 65520, 1};
        vecs[9]  = '{65521, 40000, 30000, 4479,  10000};
        vecs[10] = '{3,    2,    1,    0,    1};
        vecs[11] = '{3,    1,    2,    0,    2};
        vecs[12] = '{17,   5,    12,   0,    10};
        vecs[13] = '{17,   16,   0,    16,   16};

        drive(7681, 1234, 567);
        #1 reset = 1'b1;
        #1;
        check("reset_async_top", bus.ntt_top_o, 0);
        check("reset_async_bot", bus.ntt_bot_o, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_top", bus.ntt_top_o, 0);
        check("reset_held_bot", bus.ntt_bot_o, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("release_pre_edge_top", bus.ntt_top_o, 0);
        @(posedge clk);
        #1;
        check("release_top", bus.ntt_top_o, 1801);
        check("release_bot", bus.ntt_bot_o, 667);

        // Consecutive cycles, modulus changes between vectors.
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].q, vecs[i].a, vecs[i].b);
            $display("[TB] vec %0d q=%0d a=%0d b=%0d -> top=%0d bot=%0d", i, vecs[i].q,
                     vecs[i].a, vecs[i].b, bus.ntt_top_o, bus.ntt_bot_o);
            check($sformatf("vec%0d_top", i), bus.ntt_top_o, vecs[i].exp_top);
            check($sformatf("vec%0d_bot", i), bus.ntt_bot_o, vecs[i].exp_bot);
        end

        // Constant inputs: outputs hold across several edges.
        apply(7681, 7000, 1000);
        hold_top = bus.ntt_top_o;
        hold_bot = bus.ntt_bot_o;
        repeat (3) @(posedge clk);
        #1;
        check("hold_top", bus.ntt_top_o, 319);
        check("hold_bot", bus.ntt_bot_o, 6000);
        check("hold_top_stable", bus.ntt_top_o, hold_top);

        // Mid-stream reset clears immediately and drops the pending result.
        @(negedge clk);
        drive(7681, 10, 20);
        #2 reset = 1'b1;
        #1;
        check("midreset_top", bus.ntt_top_o, 0);
        check("midreset_bot", bus.ntt_bot_o, 0);
        @(posedge clk);
        #1;
        check("midreset_edge_top", bus.ntt_top_o, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(7681, 100, 50);
        @(posedge clk);
        #1;
        check("post_reset_top", bus.ntt_top_o, 150);
        check("post_reset_bot", bus.ntt_bot_o, 50);

        // Random back-to-back sweep.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom_range(0, 7680);
            rb = $urandom_range(0, 7680);
            apply(7681, ra, rb);
            check($sformatf("rand%0d_top a=%0d b=%0d", i, ra, rb), bus.ntt_top_o, (ra + rb) % 7681);
            check($sformatf("rand%0d_bot a=%0d b=%0d", i, ra, rb), bus.ntt_bot_o, (ra + 7681 - rb) % 7681);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
